// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive buffer with 16550-style FIFO or single holding register,
// line-status flags, trigger level and character-timeout indication.
module uart_rx_fifo #(
    parameter int DEPTH          = 16,
    parameter int ADDR_W         = 4,
    parameter int TIMEOUT_CYCLES = 640,
    parameter int TMO_W          = 10
) (
    input  logic              bclk_in,
    input  logic              rstn_in,
    input  logic              char_valid_in,
    input  logic [7:0]        char_data_in,
    input  logic              parity_err_in,
    input  logic              frame_err_in,
    input  logic              break_in,
    input  logic              fen_in,
    input  logic              fifo_clr_in,
    input  logic [1:0]        trig_lvl_in,
    input  logic              rd_en_in,
    input  logic              lsr_rd_in,
    output logic [7:0]        rbr_out,
    output logic              dr_out,
    output logic              oe_out,
    output logic              pe_out,
    output logic              fe_out,
    output logic              bi_out,
    output logic              fifo_err_out,
    output logic              trig_out,
    output logic              timeout_out,
    output logic [ADDR_W:0]   count_out
);
    logic [10:0]       r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [ADDR_W:0]   r_count, r_err_cnt;
    logic [TMO_W-1:0]  r_tmo;
    logic              r_oe, r_fen;
    logic [ADDR_W:0]   w_cap, w_trig_n;
    logic [10:0]       w_head;
    logic              w_empty, w_flush, w_pop, w_push, w_ovr;
    logic              w_push_err, w_pop_err, w_tmo_run, w_tmo_hit;

    always_comb begin
        w_cap      = fen_in ? (ADDR_W+1)'(DEPTH) : (ADDR_W+1)'(1);
        w_trig_n   = trig_lvl_in == 2'd0 ? (ADDR_W+1)'(1) :
                     trig_lvl_in == 2'd1 ? (ADDR_W+1)'(4) :
                     trig_lvl_in == 2'd2 ? (ADDR_W+1)'(8) : (ADDR_W+1)'(14);
        w_head     = r_mem[r_rd_ptr];
        w_empty    = r_count == '0;
        // A change of mode is treated exactly like an explicit flush request
        w_flush    = fifo_clr_in | (fen_in != r_fen);
        w_pop      = rd_en_in & ~w_empty & ~w_flush;
        w_push     = char_valid_in & ~w_flush & ((r_count < w_cap) | w_pop);
        w_ovr      = char_valid_in & ~w_flush & ~w_push;
        w_push_err = w_push & (parity_err_in | frame_err_in | break_in);
        w_pop_err  = w_pop & |w_head[10:8];
        w_tmo_run  = fen_in & ~w_empty & (r_count < w_trig_n);
        w_tmo_hit  = r_tmo == TMO_W'(TIMEOUT_CYCLES);
    end

    always_ff @(posedge bclk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_err_cnt <= '0;
            r_tmo     <= '0;
            r_oe      <= 1'b0;
            r_fen     <= 1'b0;
        end else begin
            r_fen <= fen_in;
            r_oe  <= w_ovr ? 1'b1 : lsr_rd_in ? 1'b0 : r_oe;
            if (w_flush) begin
                r_wr_ptr  <= '0;
                r_rd_ptr  <= '0;
                r_count   <= '0;
                r_err_cnt <= '0;
                r_tmo     <= '0;
            end else begin
                r_wr_ptr  <= r_wr_ptr + ADDR_W'(w_push);
                r_rd_ptr  <= r_rd_ptr + ADDR_W'(w_pop);
                r_count   <= r_count + (ADDR_W+1)'(w_push) - (ADDR_W+1)'(w_pop);
                r_err_cnt <= r_err_cnt + (ADDR_W+1)'(w_push_err) - (ADDR_W+1)'(w_pop_err);
                r_tmo     <= (w_push | w_pop | ~w_tmo_run) ? '0 :
                             w_tmo_hit ? r_tmo : r_tmo + TMO_W'(1);
            end
        end
    end

    always_ff @(posedge bclk_in) begin
        if (w_push)
            r_mem[r_wr_ptr] <= {break_in, frame_err_in, parity_err_in, char_data_in};
    end

    always_comb begin
        rbr_out      = w_empty ? 8'h00 : w_head[7:0];
        pe_out       = ~w_empty & w_head[8];
        fe_out       = ~w_empty & w_head[9];
        bi_out       = ~w_empty & w_head[10];
        dr_out       = ~w_empty;
        oe_out       = r_oe;
        fifo_err_out = r_err_cnt != '0;
        trig_out     = fen_in ? (r_count >= w_trig_n) : ~w_empty;
        timeout_out  = fen_in & w_tmo_hit;
        count_out    = r_count;
    end
endmodule
